line_buffer_scanout: RTL and testbench

// Read end of the sprite line buffer. Ping-pong pair of DISPLAY_WIDTH-entry RGB line banks:
// - the sprite drawer writes the back bank for the next line;
// - the front bank is streamed out one pixel per clock, indexed by sx, to the video output stage.

---
 rtl/line_buffer_scanout.sv | 156 +++++++++++++++
 tb/tb_line_buffer_scanout.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_scanout.sv
// Sprite line buffer, read end.
// Two DISPLAY_WIDTH-entry RGB banks used as a ping-pong pair. The drawer fills
// the back bank while the front bank is streamed out one pixel per clock. At
// line_start the banks swap, provided the back line is complete. The new back
// bank is then swept to BG_COLOR so the next line starts clean.
module line_buffer_scanout #(
  parameter int COLOR_DEPTH       = 8,
  parameter int DISPLAY_WIDTH     = 600,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH),
  parameter logic [3*COLOR_DEPTH-1:0] BG_COLOR = 24'h000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [LINE_NUMBER_WIDTH-1:0] wr_x,
  input  logic [3*COLOR_DEPTH-1:0]     wr_rgb,
  input  logic                         wr_done,
  output logic                         wr_ready,
  input  logic                         line_start,
  input  logic [LINE_NUMBER_WIDTH-1:0] sx,
  input  logic                         de,
  output logic [3*COLOR_DEPTH-1:0]     pix_rgb,
  output logic                         pix_valid,
  output logic                         underrun
);

  localparam int RGB_W = 3 * COLOR_DEPTH;
  localparam logic [LINE_NUMBER_WIDTH-1:0] LAST_X    = LINE_NUMBER_WIDTH'(DISPLAY_WIDTH - 1);
  localparam logic [LINE_NUMBER_WIDTH:0]   WIDTH_EXT = (LINE_NUMBER_WIDTH + 1)'(DISPLAY_WIDTH);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                       state, state_next;
  logic [LINE_NUMBER_WIDTH-1:0] clr_x, clr_x_next;
  logic                         rd_bank;      // bank currently being scanned out
  logic                         front_valid;  // front bank holds a completed line
  logic                         swap;
  logic                         mem_we;
  logic [LINE_NUMBER_WIDTH-1:0] mem_addr;
  logic [RGB_W-1:0]             mem_data;
  logic [RGB_W-1:0]             front_pix;

  logic [RGB_W-1:0] bank0 [DISPLAY_WIDTH];
  logic [RGB_W-1:0] bank1 [DISPLAY_WIDTH];

  // Back-bank FSM: next state, clear sweep, drawer writes and swap decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_next = state;
    clr_x_next = clr_x;
    swap       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = clr_x;
    mem_data   = BG_COLOR;
    wr_ready   = 1'b0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_x == LAST_X) begin
          clr_x_next = '0;
          state_next = FILL;
        end else begin
          clr_x_next = clr_x + 1'b1;
        end
      end
      FILL: begin
        wr_ready = 1'b1;
        // Out-of-range x is silently dropped.
        if (wr_en && ({1'b0, wr_x} < WIDTH_EXT)) begin
          mem_we   = 1'b1;
          mem_addr = wr_x;
          mem_data = wr_rgb;
        end
        if (wr_done) begin
          if (line_start) begin
            swap       = 1'b1;
            state_next = CLEAR;
            clr_x_next = '0;
          end else begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (line_start) begin
          swap       = 1'b1;
          state_next = CLEAR;
          clr_x_next = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        clr_x_next = '0;
      end
    endcase
  end

  // FSM state, bank select and underrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clr_x       <= '0;
      rd_bank     <= 1'b0;
      front_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_next;
      clr_x    <= clr_x_next;
      underrun <= line_start && !swap;
      if (swap) begin
        rd_bank     <= ~rd_bank;
        front_valid <= 1'b1;
      end
    end
  end

  // Bank 0 is written only while it is the back bank (rd_bank == 1).
  always_ff @(posedge clk) begin
    // NOTE: bank storage has no reset; front_valid masks stale contents instead.
    if (mem_we && rd_bank) begin
      bank0[mem_addr] <= mem_data;
    end
  end

  // Bank 1 is written only while it is the back bank (rd_bank == 0).
  always_ff @(posedge clk) begin
    if (mem_we && !rd_bank) begin
      bank1[mem_addr] <= mem_data;
    end
  end

  // Front-bank lookup, forced to BG_COLOR before the first swap or past the line end.
  always_comb begin
    front_pix = BG_COLOR;
    if (front_valid && ({1'b0, sx} < WIDTH_EXT)) begin
      front_pix = rd_bank ? bank1[sx] : bank0[sx];
    end
  end

  // Registered scan-out: one cycle of latency from sx/de to pix_rgb/pix_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= de;
      pix_rgb   <= de ? front_pix : '0;
    end
  end

endmodule

// File: tb/tb_line_buffer_scanout.sv
// Directed bench for line_buffer_scanout. The stimulus side pushes the
// expected pixel for every active-video cycle; a monitor pops and compares
// whenever pix_valid is high.
module tb_line_buffer_scanout;

  localparam int W = 600;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_x;
  logic [23:0] wr_rgb;
  logic        wr_done;
  logic        wr_ready;
  logic        line_start;
  logic [9:0]  sx;
  logic        de;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        underrun;

  line_buffer_scanout dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_rgb     (wr_rgb),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .line_start (line_start),
    .sx         (sx),
    .de         (de),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ur_cnt = 0;

  logic [23:0] exp_q[$];
  logic [23:0] model_front [W];
  logic [23:0] model_back  [W];
  logic        model_valid;
  logic        de_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // de as seen by the DUT at the last edge: pix_valid must follow it.
  always @(posedge clk or posedge reset) begin
    if (reset) de_q <= 1'b0;
    else       de_q <= de;
  end

  // Monitor: compare outputs mid-cycle, pop the scoreboard on each valid pixel.
  always @(negedge clk) begin
    if (!reset) begin
      if (underrun) ur_cnt++;
      check("pix_valid_lag", 32'(pix_valid), 32'(de_q));
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: pixel %h with no expected entry", pix_rgb);
        end else begin
          check("pix_rgb", 32'(pix_rgb), 32'(exp_q.pop_front()));
        end
      end else begin
        check("pix_rgb_idle", 32'(pix_rgb), 32'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic scan_line();
    for (int x = 0; x < W; x++) begin
      de = 1'b1;
      sx = 10'(x);
      exp_q.push_back(model_valid ? model_front[x] : BG);
      @(posedge clk); #1;
    end
    de = 1'b0;
    sx = '0;
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n = 0;
    while (!wr_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wr_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_ready_timeout: got 0 expected 1 after %0d cycles", n);
    end else if (exp_cycles >= 0) begin
      check("wr_ready_latency", 32'(n), 32'(exp_cycles));
    end
  endtask

  task automatic do_write(input int x, input logic [23:0] rgb, input bit keep);
    wr_en  = 1'b1;
    wr_x   = 10'(x);
    wr_rgb = rgb;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (keep) model_back[x] = rgb;
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
  endtask

  task automatic pulse_line_start();
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic model_swap();
    for (int i = 0; i < W; i++) begin
      model_front[i] = model_back[i];
      model_back[i]  = BG;
    end
    model_valid = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int u0;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_x = '0; wr_rgb = '0; wr_done = 1'b0;
    line_start = 1'b0; sx = '0; de = 1'b0;
    model_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      model_front[i] = BG;
      model_back[i]  = BG;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_rgb", 32'(pix_rgb), 32'(0));
    check("reset_pix_valid", 32'(pix_valid), 32'(0));
    check("reset_wr_ready", 32'(wr_ready), 32'(0));
    check("reset_underrun", 32'(underrun), 32'(0));
    reset = 1'b0;

    // 1: first line after reset is background; back bank ready after 600 cycles.
    fork
      scan_line();
      wait_ready(600);
    join

    // 2: two corner pixels, complete the line, swap.
    do_write(0, 24'hFF0000, 1'b1);
    do_write(599, 24'h00FF00, 1'b1);
    pulse_done();
    check("full_wr_ready", 32'(wr_ready), 32'(0));
    u0 = ur_cnt;
    pulse_line_start();
    model_swap();
    settle();
    check("swap_no_underrun", 32'(ur_cnt - u0), 32'(0));

    // 3: line_start during CLEAR underruns and the line repeats.
    u0 = ur_cnt;
    pulse_line_start();
    settle();
    check("underrun_clear_pulse", 32'(ur_cnt - u0), 32'(1));
    scan_line();
    check("fill_after_scan", 32'(wr_ready), 32'(1));
    u0 = ur_cnt;
    pulse_line_start();
    settle();
    check("underrun_fill_pulse", 32'(ur_cnt - u0), 32'(1));
    scan_line();
    do_write(10, 24'h123456, 1'b1);
    pulse_done();
    u0 = ur_cnt;
    pulse_line_start();
    model_swap();
    settle();
    check("swap3_no_underrun", 32'(ur_cnt - u0), 32'(0));

    // 4: writes in CLEAR, out of range and in FULL are all dropped.
    repeat (10) @(posedge clk);
    #1;
    check("clear_wr_ready", 32'(wr_ready), 32'(0));
    do_write(0, 24'h0F0F0F, 1'b0);
    wait_ready(-1);
    do_write(600, 24'hEEEEEE, 1'b0);
    do_write(1023, 24'hDDDDDD, 1'b0);
    do_write(300, 24'hABCDEF, 1'b1);
    pulse_done();
    do_write(301, 24'h111111, 1'b0);
    pulse_line_start();
    model_swap();
    scan_line();

    // 5: write, wr_done and line_start in the same FILL cycle.
    wait_ready(-1);
    u0 = ur_cnt;
    wr_en = 1'b1; wr_x = 10'd5; wr_rgb = 24'h5A5A5A; wr_done = 1'b1; line_start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_done = 1'b0; line_start = 1'b0;
    model_back[5] = 24'h5A5A5A;
    model_swap();
    settle();
    check("same_cycle_no_underrun", 32'(ur_cnt - u0), 32'(0));
    scan_line();

    // 6: reset mid-scanout, while pixel 5 of the last line is on the output.
    for (int x = 0; x < 6; x++) begin
      de = 1'b1;
      sx = 10'(x);
      exp_q.push_back(model_front[x]);
      @(posedge clk); #1;
    end
    check("pre_reset_pix", 32'(pix_rgb), 32'(model_front[5]));
    #2 reset = 1'b1;
    #1;
    check("mid_reset_pix_rgb", 32'(pix_rgb), 32'(0));
    check("mid_reset_pix_valid", 32'(pix_valid), 32'(0));
    check("mid_reset_wr_ready", 32'(wr_ready), 32'(0));
    check("mid_reset_underrun", 32'(underrun), 32'(0));
    exp_q.delete();
    de = 1'b0;
    sx = '0;
    model_valid = 1'b0;
    for (int i = 0; i < W; i++) model_back[i] = BG;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    fork
      scan_line();
      wait_ready(600);
    join

    settle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
